// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: store window feeds a byte FIFO drained by a bit-serial engine.
// Define UART_TX_PARITY_EN to add an even-parity bit to every frame (STATUS bit4 then reads 1).
module mmio_uart_tx #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] BASEADDR   = 16'hFF00,
  parameter int               DEPTH      = 4,
  parameter int               CLKSPERBIT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] writeData,
  input  logic             writeEnable,
  output logic             hit,
  output logic [WIDTH-1:0] readData,
  output logic             tx,
  output logic             txBusy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(CLKSPERBIT);
  localparam logic [TW-1:0] TLOAD = TW'(CLKSPERBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, nextState;
  logic [TW-1:0]   timer, nextTimer;
  logic [2:0]      bitIdx, nextBitIdx;
  logic [7:0]      txByte;
  logic            txNext, pop;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   rdPtr, wrPtr;
  logic [CW-1:0]   count;
  logic            overflow, enable;

  logic [WIDTH-1:0] offset;
  logic            full, empty, push, pushOk, wrStatus, wrControl;
  logic            unusedBits;

  assign offset    = address - BASEADDR;
  assign hit       = offset < WIDTH'(3);
  assign push      = writeEnable && hit && (offset[1:0] == 2'd0);
  assign wrStatus  = writeEnable && hit && (offset[1:0] == 2'd1);
  assign wrControl = writeEnable && hit && (offset[1:0] == 2'd2);
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  // A push into a full FIFO still lands when the engine pops on the same edge.
  assign pushOk    = push && (!full || pop);
  assign unusedBits = ^writeData[WIDTH-1:8];

  always_ff @(posedge clock) begin
    if (pushOk) mem[wrPtr] <= writeData[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b1;
    end else begin
      if (pushOk) wrPtr <= wrPtr + AW'(1);
      if (pop)    rdPtr <= rdPtr + AW'(1);
      if (pushOk && !pop)      count <= count + CW'(1);
      else if (!pushOk && pop) count <= count - CW'(1);
      if (wrStatus)                   overflow <= 1'b0;
      else if (push && full && !pop)  overflow <= 1'b1;
      if (wrControl) enable <= writeData[0];
    end
  end

  // Engine state register; tx is registered from the next-state decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      bitIdx <= '0;
      txByte <= '0;
      tx     <= 1'b1;
    end else begin
      state  <= nextState;
      timer  <= nextTimer;
      bitIdx <= nextBitIdx;
      tx     <= txNext;
      if (pop) txByte <= mem[rdPtr];
    end
  end

  always_comb begin
    nextState  = state;
    nextTimer  = (timer != '0) ? timer - TW'(1) : timer;
    nextBitIdx = bitIdx;
    pop        = 1'b0;
    case (state)
      IDLE: if (enable && !empty) begin
        pop = 1'b1; nextState = START; nextTimer = TLOAD;
      end
      START: if (timer == '0) begin
        nextState = DATA; nextBitIdx = '0; nextTimer = TLOAD;
      end
      DATA: if (timer == '0) begin
        nextTimer = TLOAD;
        if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          nextState = PARITY;
`else
          nextState = STOP;
`endif
        end else begin
          nextBitIdx = bitIdx + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (timer == '0) begin
        nextState = STOP; nextTimer = TLOAD;
      end
`endif
      STOP: if (timer == '0) begin
        if (enable && !empty) begin
          pop = 1'b1; nextState = START; nextTimer = TLOAD;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    txNext = 1'b1;
    txBusy = !empty || (state != IDLE);
    case (nextState)
      START:  txNext = 1'b0;
      DATA:   txNext = txByte[nextBitIdx];
`ifdef UART_TX_PARITY_EN
      PARITY: txNext = ^txByte;
`endif
      default: txNext = 1'b1;
    endcase
  end

  always_comb begin
    readData = '0;
    if (hit) begin
      case (offset[1:0])
        2'd1: begin
          readData[0]    = full;
          readData[1]    = empty;
          readData[2]    = (state != IDLE);
          readData[3]    = overflow;
`ifdef UART_TX_PARITY_EN
          readData[4]    = 1'b1;
`endif
          readData[15:8] = 8'(count);
        end
        2'd2:    readData[0] = enable;
        default: readData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: scoreboard of stored bytes checked against a serial-line decoder.
module tb_mmio_uart_tx;

  localparam int CPB = 16;
  localparam logic [15:0] BASE = 16'hFF00;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
  localparam logic [15:0] PB = 16'h0010;
`else
  localparam int FRAME = 10 * CPB;
  localparam logic [15:0] PB = 16'h0000;
`endif
  localparam logic [15:0] STATUSRST = 16'h0002 | PB;
  localparam logic [15:0] IDLEADDR = 16'h0010;

  logic        clock, reset, writeEnable, hit, tx, txBusy;
  logic [15:0] address, writeData, readData;

  int   nVec = 0, nErr = 0;
  logic [7:0] sbQ [$];
  logic abortFrame = 1'b0;
  logic [7:0] rxByte, expByte;
  logic rxStart, rxStop, rxPar;
  int   n, lowCnt;

  mmio_uart_tx #(.WIDTH(16), .BASEADDR(BASE), .DEPTH(4), .CLKSPERBIT(CPB)) dut (
    .clock(clock), .reset(reset), .address(address), .writeData(writeData),
    .writeEnable(writeEnable), .hit(hit), .readData(readData), .tx(tx), .txBusy(txBusy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    address = a; writeData = d; writeEnable = 1'b1;
    @(negedge clock);
    writeEnable = 1'b0; address = IDLEADDR;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic expHit, input logic [15:0] expData);
    @(negedge clock);
    address = a;
    #1;
    chk({tag, "_hit"}, 32'(hit), 32'(expHit));
    chk({tag, "_data"}, 32'(readData), 32'(expData));
    address = IDLEADDR;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (txBusy && cycles < 5000) begin
      @(posedge clock); #1;
      cycles++;
    end
  endtask

  // Serial decoder: samples each bit at its midpoint and pops the scoreboard.
  always @(posedge reset) abortFrame = 1'b1;

  initial forever begin
    @(negedge tx);
    abortFrame = 1'b0;
    repeat (CPB / 2) @(posedge clock);
    #1 rxStart = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clock);
      #1 rxByte[i] = tx;
    end
    rxPar = 1'b0;
`ifdef UART_TX_PARITY_EN
    repeat (CPB) @(posedge clock);
    #1 rxPar = tx;
`endif
    repeat (CPB) @(posedge clock);
    #1 rxStop = tx;
    if (!abortFrame) begin
      chk("startBit", 32'(rxStart), 32'd0);
      chk("sbNotEmpty", 32'(sbQ.size() > 0), 32'd1);
      if (sbQ.size() > 0) begin
        expByte = sbQ.pop_front();
        chk("rxByte", 32'(rxByte), 32'(expByte));
`ifdef UART_TX_PARITY_EN
        chk("parityBit", 32'(rxPar), 32'(^expByte));
`endif
      end
      chk("stopBit", 32'(rxStop), 32'd1);
    end
  end

  initial begin
    reset = 1'b1; address = IDLEADDR; writeData = '0; writeEnable = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rstTx", 32'(tx), 32'd1);
    chk("rstBusy", 32'(txBusy), 32'd0);
    @(negedge clock) reset = 1'b0;

    // Register window and boundaries
    rd("rstStatus", BASE + 16'd1, 1'b1, STATUSRST);
    rd("outLow", IDLEADDR, 1'b0, 16'h0000);
    rd("outHigh", BASE + 16'd3, 1'b0, 16'h0000);
    rd("ctrlRst", BASE + 16'd2, 1'b1, 16'h0001);
    rd("txdataRd", BASE, 1'b1, 16'h0000);

    // Single frame, upper byte ignored
    store(BASE, 16'h1255); sbQ.push_back(8'h55);
    chk("txBeforePop", 32'(tx), 32'd1);
    @(posedge clock); #1;
    chk("startEdge", 32'(tx), 32'd0);
    waitIdle(n);
    chk("frameLen", 32'(n), 32'(FRAME));
    rd("statusIdle", BASE + 16'd1, 1'b1, STATUSRST);

    // Five consecutive stores: one pops on the second edge, so none overflow
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      address = BASE; writeData = 16'(16'hA0 + i); writeEnable = 1'b1;
      sbQ.push_back(8'(8'hA0 + i));
    end
    @(negedge clock) begin writeEnable = 1'b0; address = IDLEADDR; end
    rd("burstStatus", BASE + 16'd1, 1'b1, 16'h0405 | PB);
    waitIdle(n);
    chk("burstLen", 32'(n), 32'(5 * FRAME - 4));

    // Disabled engine: fill, overflow, clear, re-enable
    store(BASE + 16'd2, 16'h0000);
    rd("ctrlOff", BASE + 16'd2, 1'b1, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      store(BASE, 16'(16'h30 + i));
      if (i < 4) sbQ.push_back(8'(8'h30 + i));
    end
    rd("ovfStatus", BASE + 16'd1, 1'b1, 16'h0409 | PB);
    store(BASE + 16'd1, 16'hFFFF);
    rd("ovfClr", BASE + 16'd1, 1'b1, 16'h0401 | PB);
    chk("heldIdle", 32'(tx), 32'd1);
    store(BASE + 16'd2, 16'h0001);
    waitIdle(n);
    chk("drainLen", 32'(n), 32'(4 * FRAME + 1));
    rd("ctrlOn", BASE + 16'd2, 1'b1, 16'h0001);

    // Reset in the middle of a data bit
    store(BASE, 16'h0000); sbQ.push_back(8'h00);
    repeat (40) @(posedge clock);
    #1;
    chk("midData", 32'(tx), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("asyncTx", 32'(tx), 32'd1);
    chk("asyncBusy", 32'(txBusy), 32'd0);
    sbQ.delete();
    @(negedge clock) reset = 1'b0;
    rd("postRst", BASE + 16'd1, 1'b1, STATUSRST);
    lowCnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      if (tx !== 1'b1) lowCnt++;
    end
    chk("noFrames", 32'(lowCnt), 32'd0);
    chk("idleBusy", 32'(txBusy), 32'd0);

    // Byte with odd bit count (parity bit 1 when parity is compiled in)
    store(BASE, 16'h0007); sbQ.push_back(8'h07);
    @(posedge clock); #1;
    waitIdle(n);
    chk("frameLen07", 32'(n), 32'(FRAME));

    repeat (20) @(posedge clock);
    #1;
    chk("sbDrained", 32'(sbQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
